// File: rtl/jtbubl_gfx_romslot.sv
// jtbubl_gfx_romslot: graphics ROM responder with a tag cache in front of the SDRAM arbiter.
// Build option JTBUBL_ROMSLOT_2WAY_EN selects a two-entry cache with 1-bit LRU replacement.
module jtbubl_gfx_romslot #(
  parameter int          AW     = 19,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gfx_cs,
  input  logic [AW-1:0] gfx_addr,
  output logic [15:0]   gfx_data,
  output logic          gfx_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [31:0]   sdram_data
);

`ifdef JTBUBL_ROMSLOT_2WAY_EN
  localparam int WAYS = 2;
`else
  localparam int WAYS = 1;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t          r_state;
  logic [WAYS-1:0] r_valid;
  logic [AW-2:0]   r_tag  [WAYS];
  logic [31:0]     r_line [WAYS];
  logic [AW-2:0]   r_pend_tag;
  logic [15:0]     r_data_hold;

  logic [AW-2:0]   w_tag;
  logic [WAYS-1:0] w_match;
  logic [WAYS-1:0] w_fill_oh;
  logic [31:0]     w_line;
  logic [15:0]     w_word;
  logic            w_hit;
  logic            w_fill;
  logic [21:0]     w_line_addr;

  assign w_tag = gfx_addr[AW-1:1];

  always_comb begin
    w_match = '0;
    w_line  = r_line[0];
    for (int i = 0; i < WAYS; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == w_tag);
      if (w_match[i]) w_line = r_line[i];
    end
  end

  assign w_word      = gfx_addr[0] ? w_line[31:16] : w_line[15:0];
  assign w_hit       = gfx_cs & (|w_match);
  assign gfx_ok      = w_hit;
  assign gfx_data    = w_hit ? w_word : r_data_hold;
  assign w_line_addr = OFFSET + 22'({w_tag, 1'b0});
  // ack and strobe together in WAIT_ACK counts as a complete transfer
  assign w_fill      = sdram_dst & ((r_state == WAIT_DATA) | ((r_state == WAIT_ACK) & sdram_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      r_pend_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (gfx_cs && !(|w_match)) begin
            r_pend_tag <= w_tag;
            sdram_req  <= 1'b1;
            sdram_addr <= w_line_addr;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            r_state   <= sdram_dst ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_dst) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_data_hold <= '0;
      for (int i = 0; i < WAYS; i++) begin
        r_tag[i]  <= '0;
        r_line[i] <= '0;
      end
    end else begin
      if (w_hit) r_data_hold <= w_word;
      for (int i = 0; i < WAYS; i++) begin
        if (w_fill && w_fill_oh[i]) begin
          r_valid[i] <= 1'b1;
          r_tag[i]   <= r_pend_tag;
          r_line[i]  <= sdram_data;
        end
      end
    end
  end

`ifdef JTBUBL_ROMSLOT_2WAY_EN
  // r_lru points at the entry to replace next
  logic r_lru;

  assign w_fill_oh = r_lru ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lru <= 1'b0;
    end else if (w_fill) begin
      r_lru <= ~r_lru;
    end else if (w_hit) begin
      r_lru <= ~w_match[1];
    end
  end
`else
  assign w_fill_oh = 1'b1;
`endif

endmodule
